// File: rtl/note_sequencer_if.sv
// Note-table read port: the sequencer requests an address and the table answers
// with a one-cycle acknowledge carrying the 16-bit note word.
interface note_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              NoteReq;
  logic [ADDR_W-1:0] NoteAddr;
  logic              NoteAck;
  logic [15:0]       NoteData;

  modport master (output NoteReq, NoteAddr, input NoteAck, NoteData);
  modport slave  (input NoteReq, NoteAddr, output NoteAck, NoteData);
endinterface

// File: rtl/note_sequencer.sv
// Walks a note table from address 0, loading each note's divider limit into a tone
// generator for duration*TICK_DIV cycles, followed by an optional silent gap.
module note_sequencer #(
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 2,
  parameter int ADDR_W    = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stop,
  note_sequencer_if.master   Note,
  output logic [10:0]        ToneLimit,
  output logic               ToneLoad,
  output logic               ToneEnable,
  output logic               Playing,
  output logic               Done
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [4:0]        GAP_LAST  = (GAP_TICKS > 0) ? 5'(GAP_TICKS - 1) : 5'd0;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} stateType;

  stateType         state;
  logic [PRE_W-1:0] prescale;
  logic [4:0]       tickCount;
  logic [4:0]       noteDur;
  logic             tickDone;
  logic             noteLast;
  logic             gapLast;
  logic             noteOver;

  // noteOver marks the last cycle of a note including its gap (if any).
  always_comb begin
    tickDone = (prescale == PRE_LAST);
    noteLast = tickDone && (tickCount == noteDur - 5'd1);
    gapLast  = tickDone && (tickCount == GAP_LAST);
    noteOver = ((state == LOAD || state == PLAY) && noteLast && (GAP_TICKS == 0)) ||
               ((state == GAP) && gapLast);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      prescale      <= '0;
      tickCount     <= '0;
      noteDur       <= '0;
      Note.NoteReq  <= 1'b0;
      Note.NoteAddr <= '0;
      ToneLimit     <= '0;
      ToneLoad      <= 1'b0;
      ToneEnable    <= 1'b0;
      Playing       <= 1'b0;
      Done          <= 1'b0;
    end else begin
      ToneLoad <= 1'b0;
      Done     <= 1'b0;
      if (Stop) begin
        state        <= IDLE;
        Note.NoteReq <= 1'b0;
        ToneEnable   <= 1'b0;
        Playing      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Start) begin
              state         <= FETCH;
              Note.NoteAddr <= '0;
              Note.NoteReq  <= 1'b1;
              Playing       <= 1'b1;
            end
          end
          FETCH: begin
            if (Note.NoteAck) begin
              Note.NoteReq <= 1'b0;
              if (Note.NoteData[15:11] == 5'd0) begin
                state   <= IDLE;
                Done    <= 1'b1;
                Playing <= 1'b0;
              end else begin
                state      <= LOAD;
                noteDur    <= Note.NoteData[15:11];
                ToneLimit  <= Note.NoteData[10:0];
                ToneLoad   <= 1'b1;
                ToneEnable <= |Note.NoteData[10:0];
                prescale   <= '0;
                tickCount  <= '0;
              end
            end
          end
          LOAD, PLAY: begin
            state <= PLAY;
            if (tickDone) begin
              prescale  <= '0;
              tickCount <= tickCount + 5'd1;
            end else begin
              prescale <= prescale + 1'b1;
            end
            if (noteLast) begin
              ToneEnable <= 1'b0;
              prescale   <= '0;
              tickCount  <= '0;
              if (GAP_TICKS > 0) state <= GAP;
            end
          end
          GAP: begin
            if (tickDone) begin
              prescale  <= '0;
              tickCount <= tickCount + 5'd1;
            end else begin
              prescale <= prescale + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        // The last table entry ends the song instead of wrapping to address 0.
        if (noteOver) begin
          if (Note.NoteAddr == LAST_ADDR) begin
            state   <= IDLE;
            Done    <= 1'b1;
            Playing <= 1'b0;
          end else begin
            state         <= FETCH;
            Note.NoteAddr <= Note.NoteAddr + 1'b1;
            Note.NoteReq  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer (TICK_DIV=4, GAP_TICKS=1, ADDR_W=3) with a
// note-table responder that acknowledges on the third cycle of each request.
module tb_note_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Stop  = 1'b0;
  logic [10:0] ToneLimit;
  logic        ToneLoad, ToneEnable, Playing, Done;

  note_sequencer_if #(.ADDR_W(3)) bus ();

  logic        autoAck   = 1'b0;
  logic        forceAck  = 1'b0;
  logic [15:0] autoData  = 16'h0;
  logic [15:0] forceData = 16'h0;
  logic [15:0] noteTable [8];
  int waitCnt = 0, ackCount = 0, loadCount = 0, doneCount = 0, enableCount = 0;
  int total = 0, bad = 0;

  assign bus.NoteAck  = autoAck | forceAck;
  assign bus.NoteData = forceAck ? forceData : autoData;

  note_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .ADDR_W(3)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Note(bus),
    .ToneLimit(ToneLimit), .ToneLoad(ToneLoad), .ToneEnable(ToneEnable),
    .Playing(Playing), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Table model: ack on the third negedge of a request, drop it one cycle later.
  always @(negedge Clock) begin
    if (autoAck) begin
      autoAck = 1'b0;
      waitCnt = 0;
    end else if (bus.NoteReq) begin
      if (waitCnt == 2) begin
        autoAck  = 1'b1;
        autoData = noteTable[bus.NoteAddr];
        ackCount++;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
  end

  always @(posedge Clock) begin
    #1;
    if (ToneLoad)   loadCount++;
    if (Done)       doneCount++;
    if (ToneEnable) enableCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] seen, input logic [31:0] want);
    total++;
    if (seen !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, seen, want);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    Start = s;
    Stop  = p;
    @(negedge Clock);
    Start = 1'b0;
    Stop  = 1'b0;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return ToneLoad;
      1:       return bus.NoteReq;
      2:       return Done;
      default: return ToneEnable;
    endcase
  endfunction

  task automatic waitFor(input int sel, input int maxc, output int n);
    n = 0;
    while (pick(sel) !== 1'b1 && n < maxc) begin
      @(negedge Clock);
      n++;
    end
    if (pick(sel) !== 1'b1) checkOutput("wait timeout", 32'(pick(sel)), 32'd1);
  endtask

  task automatic countRun(input int sel, input logic val, input int maxc, output int n);
    n = 0;
    while (pick(sel) === val && n < maxc) begin
      n++;
      @(negedge Clock);
    end
  endtask

  initial begin
    int n, l0, d0, e0, a0;
    for (int i = 0; i < 8; i++) noteTable[i] = 16'h0;

    repeat (3) @(negedge Clock);
    checkOutput("reset NoteReq", bus.NoteReq, 0);
    checkOutput("reset NoteAddr", bus.NoteAddr, 0);
    checkOutput("reset ToneLimit", ToneLimit, 0);
    checkOutput("reset Playing", Playing, 0);
    checkOutput("reset ToneEnable", ToneEnable, 0);
    Reset = 1'b0;
    @(negedge Clock);

    // Single sounding note followed by end-of-song entry.
    noteTable[0] = 16'h1C6A;
    noteTable[1] = 16'h0000;
    l0 = loadCount;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1 NoteReq", bus.NoteReq, 1);
    checkOutput("t1 NoteAddr", bus.NoteAddr, 0);
    checkOutput("t1 Playing", Playing, 1);
    waitFor(0, 20, n);
    checkOutput("t1 load latency", n, 3);
    checkOutput("t1 ToneLimit", ToneLimit, 11'h46A);
    checkOutput("t1 ToneEnable", ToneEnable, 1);
    checkOutput("t1 NoteReq low", bus.NoteReq, 0);
    countRun(3, 1'b1, 50, n);
    checkOutput("t1 tone cycles", n, 12);
    countRun(1, 1'b0, 50, n);
    checkOutput("t1 gap cycles", n, 4);
    checkOutput("t1 next addr", bus.NoteAddr, 1);
    waitFor(2, 20, n);
    checkOutput("t1 done latency", n, 3);
    checkOutput("t1 Playing end", Playing, 0);
    @(negedge Clock);
    checkOutput("t1 Done one cycle", Done, 0);
    checkOutput("t1 load count", loadCount - l0, 1);
    checkOutput("t1 ToneLimit kept", ToneLimit, 11'h46A);

    // Rest entry: load pulses but the tone never sounds.
    noteTable[0] = 16'h0800;
    l0 = loadCount;
    e0 = enableCount;
    applyStimulus(1'b1, 1'b0);
    waitFor(0, 20, n);
    checkOutput("t2 load latency", n, 3);
    checkOutput("t2 ToneLimit", ToneLimit, 0);
    checkOutput("t2 ToneEnable", ToneEnable, 0);
    countRun(1, 1'b0, 50, n);
    checkOutput("t2 rest+gap cycles", n, 8);
    checkOutput("t2 next addr", bus.NoteAddr, 1);
    waitFor(2, 20, n);
    checkOutput("t2 enable cycles", enableCount - e0, 0);
    checkOutput("t2 load count", loadCount - l0, 1);

    // Stop five cycles into the note.
    noteTable[0] = 16'h1C6A;
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0);
    waitFor(0, 20, n);
    repeat (5) @(negedge Clock);
    checkOutput("t3 sounding", ToneEnable, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t3 Playing", Playing, 0);
    checkOutput("t3 ToneEnable", ToneEnable, 0);
    checkOutput("t3 NoteReq", bus.NoteReq, 0);
    checkOutput("t3 ToneLimit held", ToneLimit, 11'h46A);
    repeat (6) @(negedge Clock);
    checkOutput("t3 no Done", doneCount - d0, 0);
    checkOutput("t3 still idle", Playing, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3 restart req", bus.NoteReq, 1);
    checkOutput("t3 restart addr", bus.NoteAddr, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t3 stopped", Playing, 0);

    // Start with Stop in IDLE, then a stray ack while idle.
    l0 = loadCount;
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5 NoteReq", bus.NoteReq, 0);
    checkOutput("t5 Playing", Playing, 0);
    forceData = 16'h1C6A;
    forceAck  = 1'b1;
    @(negedge Clock);
    forceAck  = 1'b0;
    checkOutput("t5 ack Playing", Playing, 0);
    checkOutput("t5 ack ToneLoad", ToneLoad, 0);
    @(negedge Clock);
    checkOutput("t5 load count", loadCount - l0, 0);

    // Held Start restarts the song right after Done.
    noteTable[0] = 16'h0800;
    Start = 1'b1;
    @(negedge Clock);
    waitFor(2, 100, n);
    checkOutput("t7 done latency", n, 14);
    @(negedge Clock);
    checkOutput("t7 restart req", bus.NoteReq, 1);
    checkOutput("t7 restart addr", bus.NoteAddr, 0);
    checkOutput("t7 Playing", Playing, 1);
    Start = 1'b0;
    applyStimulus(1'b0, 1'b1);

    // Full table: song ends after address 7 without wrapping.
    for (int i = 0; i < 8; i++) noteTable[i] = 16'h0801;
    a0 = ackCount;
    l0 = loadCount;
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0);
    waitFor(2, 400, n);
    checkOutput("t4 done latency", n, 88);
    checkOutput("t4 Playing", Playing, 0);
    checkOutput("t4 final addr", bus.NoteAddr, 7);
    repeat (10) @(negedge Clock);
    checkOutput("t4 no refetch", bus.NoteReq, 0);
    checkOutput("t4 ack count", ackCount - a0, 8);
    checkOutput("t4 load count", loadCount - l0, 8);
    checkOutput("t4 done count", doneCount - d0, 1);

    // Reset lands on the same edge as the note ack.
    noteTable[0] = 16'h1C6A;
    l0 = loadCount;
    applyStimulus(1'b1, 1'b0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    checkOutput("t6 NoteReq", bus.NoteReq, 0);
    checkOutput("t6 NoteAddr", bus.NoteAddr, 0);
    checkOutput("t6 ToneLimit", ToneLimit, 0);
    checkOutput("t6 ToneLoad", ToneLoad, 0);
    checkOutput("t6 ToneEnable", ToneEnable, 0);
    checkOutput("t6 Playing", Playing, 0);
    checkOutput("t6 Done", Done, 0);
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("t6 load count", loadCount - l0, 0);
    checkOutput("t6 idle", Playing, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
